seq_pattern_tx: RTL and testbench

Serial pattern transmitter that drives single-bit sequence streams into the team's sequence-detector FSMs (e.g. the overlapping 1010 Mealy detector). It captures a WIDTH-bit pattern on a start handshake and shifts it out MSB-first, one bit per DIV clocks. It supports single-shot or back-to-back repeated frames, so overlapping-detection cases can be generated. It sits on the stimulus side of the detector `d` input, as a bench driver or an on-chip pattern source.

---
 rtl/seq_pattern_tx.sv | 135 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : Serial MSB-first pattern transmitter with optional repeated frames.
// Revision : 1.0
// ============================================================================
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pat,
  input  logic             repeat_en,
  input  logic             stop,
  output logic             d,
  output logic             valid,
  output logic             busy,
  output logic             ready,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] C_BITS   = BW'(WIDTH);
  localparam logic [DW-1:0] C_DIVRLD = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic             d_q, d_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      d_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    div_d   = div_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pat;
          sh_d    = pat;
          bit_d   = C_BITS;
          div_d   = C_DIVRLD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DW'(1);
        end else if (bit_q == BW'(1)) begin
          // Frame boundary: the only point where repeat_en and stop are sampled.
          if (repeat_en && !stop) begin
            sh_d  = pat_q;
            bit_d = C_BITS;
            div_d = C_DIVRLD;
          end else begin
            bit_d   = '0;
            state_d = DONE;
          end
        end else begin
          sh_d  = sh_q << 1;
          bit_d = bit_q - BW'(1);
          div_d = C_DIVRLD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pat_d   = '0;
        sh_d    = '0;
        bit_d   = '0;
        div_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    valid_d = (state_d == SHIFT);
    d_d     = (state_d == SHIFT) && sh_d[WIDTH-1];
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  assign d     = d_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Purpose  : Directed self-checking bench for seq_pattern_tx (DIV=1 and DIV=3).
// Revision : 1.0
// ============================================================================
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic [3:0] pat;
  logic       repeat_en, stop;
  logic       d1, valid1, busy1, ready1, done1;
  logic       d3, valid3, busy3, ready3, done3;
  logic [4:0] obs1, obs3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pat(pat),
    .repeat_en(repeat_en), .stop(stop),
    .d(d1), .valid(valid1), .busy(busy1), .ready(ready1), .done(done1)
  );

  seq_pattern_tx #(.WIDTH(4), .DIV(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .pat(pat),
    .repeat_en(repeat_en), .stop(stop),
    .d(d3), .valid(valid3), .busy(busy3), .ready(ready3), .done(done3)
  );

  // Observation vector: {d, valid, busy, done, ready}
  assign obs1 = {d1, valid1, busy1, done1, ready1};
  assign obs3 = {d3, valid3, busy3, done3, ready3};

  localparam logic [4:0] C_IDLE = 5'b00001;
  localparam logic [4:0] C_DONE = 5'b00110;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] bitv(input logic b);
    return {b, 4'b1100};
  endfunction

  initial begin
    logic [3:0]  hist;
    int          hits;
    int          dones;
    logic [11:0] rep_exp;
    logic [3:0]  p;

    reset = 1'b0; start1 = 1'b1; start3 = 1'b1; pat = 4'b1010;
    repeat_en = 1'b0; stop = 1'b0;

    // Reset held with start asserted: nothing may start.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_dut1", obs1, C_IDLE);
      check("reset_dut3", obs3, C_IDLE);
    end
    start1 = 1'b0; start3 = 1'b0; reset = 1'b1;
    tick();
    check("post_reset_idle", obs1, C_IDLE);

    // Single frame 1010, DIV=1.
    p = 4'b1010; pat = p; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("single_bit%0d", i), obs1, bitv(p[3-i]));
      tick();
    end
    check("single_done", obs1, C_DONE);
    tick();
    check("single_ready", obs1, C_IDLE);

    // Repeat mode, live pat changed after capture, stop raised in frame 3.
    rep_exp = 12'b1010_1010_1010; hist = '0; hits = 0;
    pat = 4'b1010; repeat_en = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0; pat = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("repeat_bit%0d", i), obs1, bitv(rep_exp[11-i]));
      hist = {hist[2:0], d1};
      if (valid1 && hist == 4'b1010) hits++;
      if (i == 9) stop = 1'b1;
      tick();
    end
    check("repeat_done", obs1, C_DONE);
    n_checks++;
    assert (hits == 5) else begin
      n_fail++;
      $error("FAIL repeat_overlap_hits: observed %0d expected 5", hits);
    end
    tick();
    check("repeat_ready", obs1, C_IDLE);
    stop = 1'b0; repeat_en = 1'b0;

    // Bit period DIV=3, pattern 1100.
    pat = 4'b1100; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("div3_cyc%0d", c), obs3, bitv(c <= 6));
      tick();
    end
    check("div3_done", obs3, C_DONE);
    tick();
    check("div3_ready", obs3, C_IDLE);

    // Start while busy / in DONE is ignored.
    p = 4'b1010; pat = p; start1 = 1'b1; dones = 0;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4)      check($sformatf("ign_cyc%0d", c), obs1, bitv(p[4-c]));
      else if (c == 5) check("ign_done", obs1, C_DONE);
      else             check($sformatf("ign_idle%0d", c), obs1, C_IDLE);
      if (done1) dones++;
      if (c == 2) begin start1 = 1'b1; pat = 4'b0110; end
      if (c == 5) start1 = 1'b0;
      tick();
    end
    n_checks++;
    assert (dones == 1) else begin
      n_fail++;
      $error("FAIL ign_done_count: observed %0d expected 1", dones);
    end

    // Abort by reset during bit 2, then a fresh frame 0111.
    pat = 4'b1010; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("abort_bit1", obs1, bitv(1'b1));
    tick();
    check("abort_bit2", obs1, bitv(1'b0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_idle", obs1, C_IDLE);
    tick();
    check("abort_no_done", obs1, C_IDLE);
    p = 4'b0111; pat = p; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fresh_bit%0d", i), obs1, bitv(p[3-i]));
      tick();
    end
    check("fresh_done", obs1, C_DONE);
    tick();
    check("fresh_ready", obs1, C_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
